// File: rtl/nwc_job_scheduler.sv
// In-order job dispatcher for NUM_CH parallel nwc_top channels with per-channel completion tracking.
// Optional per-channel RUN watchdog enabled by defining NWC_SCHED_WATCHDOG_EN.
module nwc_job_scheduler #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned LOG_CH         = 2,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          job_valid,
  input  logic [LOG_CH-1:0]             job_ch,
  output logic                          job_ready,
  output logic [NUM_CH-1:0]             ch_start,
  input  logic [NUM_CH-1:0]             ch_start_ready,
  input  logic [NUM_CH-1:0]             ch_mem_wr,
  input  logic [NUM_CH-1:0]             ch_out_ready,
  output logic [NUM_CH-1:0]             ch_busy,
  output logic                          done_valid,
  output logic [LOG_CH-1:0]             done_ch,
  output logic                          done_err,
  input  logic                          done_ready,
  output logic [$clog2(FIFO_DEPTH):0]   q_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (NUM_CH < 2 || NUM_CH > 8 || LOG_CH != $clog2(NUM_CH) || TIMEOUT_CYCLES == 0 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("nwc_job_scheduler: invalid parameter set");
  end

  typedef enum logic [1:0] {CH_FREE, CH_ARMED, CH_RUN} ch_state_e;

  ch_state_e             state_q [NUM_CH];
  ch_state_e             state_d [NUM_CH];
  logic [NUM_CH-1:0]     seen_q, seen_d;      // mem_wr observed low during the current RUN
  logic [NUM_CH-1:0]     out_q;               // last-cycle sample of ch_out_ready
  logic [NUM_CH-1:0]     pend_q, pend_d;
  logic [NUM_CH-1:0]     err_q, err_d;
  logic [NUM_CH-1:0]     start_d, busy_d;
  logic                  done_valid_d, done_err_d, job_ready_d;
  logic [LOG_CH-1:0]     done_ch_d;
  logic [CNT_W-1:0]      q_count_d;
  logic [LOG_CH-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [LOG_CH-1:0]     head_ch;
  logic                  push, pop, head_free;
`ifdef NWC_SCHED_WATCHDOG_EN
  logic [31:0]           wd_cnt_q [NUM_CH];
  logic [31:0]           wd_cnt_d [NUM_CH];
`endif

  assign head_ch = fifo_mem[rd_ptr];

  // Next-state: queue, channel FSMs, completion record
  always_comb begin
    push      = job_valid & job_ready;
    head_free = 1'b0;
    seen_d    = seen_q;
    pend_d    = pend_q;
    err_d     = err_q;
    start_d   = '0;
    busy_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
`ifdef NWC_SCHED_WATCHDOG_EN
      wd_cnt_d[i] = wd_cnt_q[i];
`endif
      if (head_ch == LOG_CH'(i) && state_q[i] == CH_FREE && !pend_q[i]) head_free = 1'b1;
    end
    pop       = (q_count != '0) && head_free;
    q_count_d = q_count + CNT_W'(push) - CNT_W'(pop);
    job_ready_d = (q_count_d < CNT_W'(FIFO_DEPTH));

    for (int i = 0; i < NUM_CH; i++) begin
      if (done_valid && done_ready && done_ch == LOG_CH'(i)) pend_d[i] = 1'b0;
      case (state_q[i])
        CH_FREE: begin
          if (pop && head_ch == LOG_CH'(i)) state_d[i] = CH_ARMED;
        end
        CH_ARMED: begin
          if (ch_start_ready[i] && ch_mem_wr[i]) begin
            state_d[i] = CH_RUN;
            start_d[i] = 1'b1;
            seen_d[i]  = 1'b0;
`ifdef NWC_SCHED_WATCHDOG_EN
            wd_cnt_d[i] = '0;
`endif
          end
        end
        CH_RUN: begin
          if (!ch_mem_wr[i]) seen_d[i] = 1'b1;
`ifdef NWC_SCHED_WATCHDOG_EN
          wd_cnt_d[i] = wd_cnt_q[i] + 32'd1;
`endif
          if (seen_q[i] && !out_q[i] && ch_out_ready[i]) begin
            state_d[i] = CH_FREE;
            pend_d[i]  = 1'b1;
            err_d[i]   = 1'b0;
          end
`ifdef NWC_SCHED_WATCHDOG_EN
          else if (wd_cnt_q[i] == 32'(TIMEOUT_CYCLES - 1)) begin
            state_d[i] = CH_FREE;
            pend_d[i]  = 1'b1;
            err_d[i]   = 1'b1;
          end
`endif
        end
        default: state_d[i] = CH_FREE;
      endcase
      busy_d[i] = (state_d[i] != CH_FREE);
    end

    // Presented record holds while stalled; otherwise reload with the lowest pending channel
    done_valid_d = done_valid;
    done_ch_d    = done_ch;
    done_err_d   = done_err;
    if (!done_valid || done_ready) begin
      done_valid_d = |pend_d;
      done_ch_d    = '0;
      done_err_d   = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (pend_d[i]) begin
          done_ch_d  = LOG_CH'(i);
          done_err_d = err_d[i];
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= CH_FREE;
`ifdef NWC_SCHED_WATCHDOG_EN
        wd_cnt_q[i] <= '0;
`endif
      end
      seen_q     <= '0;
      out_q      <= '0;
      pend_q     <= '0;
      err_q      <= '0;
      ch_start   <= '0;
      ch_busy    <= '0;
      done_valid <= 1'b0;
      done_ch    <= '0;
      done_err   <= 1'b0;
      job_ready  <= 1'b1;
      q_count    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
`ifdef NWC_SCHED_WATCHDOG_EN
        wd_cnt_q[i] <= wd_cnt_d[i];
`endif
      end
      seen_q     <= seen_d;
      out_q      <= ch_out_ready;
      pend_q     <= pend_d;
      err_q      <= err_d;
      ch_start   <= start_d;
      ch_busy    <= busy_d;
      done_valid <= done_valid_d;
      done_ch    <= done_ch_d;
      done_err   <= done_err_d;
      job_ready  <= job_ready_d;
      q_count    <= q_count_d;
      if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
    end
  end

  // Queue storage, no reset needed: entries are only read below q_count
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= job_ch;
  end

endmodule

// File: tb/tb_nwc_job_scheduler.sv
// Directed bench for nwc_job_scheduler: dispatch latency, ordering, queue full, stale output_ready, reset.
module tb_nwc_job_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       job_valid;
  logic [1:0] job_ch;
  logic       job_ready;
  logic [3:0] ch_start, ch_start_ready, ch_mem_wr, ch_out_ready, ch_busy;
  logic       done_valid, done_err, done_ready;
  logic [1:0] done_ch;
  logic [3:0] q_count;

  int checks = 0;
  int errors = 0;

  nwc_job_scheduler #(
    .NUM_CH(4), .LOG_CH(2), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ch(job_ch), .job_ready(job_ready),
    .ch_start(ch_start), .ch_start_ready(ch_start_ready), .ch_mem_wr(ch_mem_wr),
    .ch_out_ready(ch_out_ready), .ch_busy(ch_busy),
    .done_valid(done_valid), .done_ch(done_ch), .done_err(done_err), .done_ready(done_ready),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; job_valid = 1'b0; job_ch = '0; done_ready = 1'b0;
    ch_start_ready = '0; ch_mem_wr = '0; ch_out_ready = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_job_ready", 32'(job_ready), 1);
    chk("rst_busy", 32'(ch_busy), 0);
    chk("rst_done_valid", 32'(done_valid), 0);
    chk("rst_q_count", 32'(q_count), 0);
    chk("rst_start", 32'(ch_start), 0);

    // single job on ch2: start two cycles after accept, completion one cycle after rise
    ch_start_ready[2] = 1'b1; ch_mem_wr[2] = 1'b1;
    job_valid = 1'b1; job_ch = 2'd2;
    tick();
    job_valid = 1'b0;
    chk("t1_q_after_accept", 32'(q_count), 1);
    chk("t1_no_start_yet", 32'(ch_start), 0);
    tick();
    chk("t1_q_after_pop", 32'(q_count), 0);
    chk("t1_busy_armed", 32'(ch_busy), 32'h4);
    chk("t1_no_start_armed", 32'(ch_start), 0);
    tick();
    chk("t1_start", 32'(ch_start), 32'h4);
    ch_start_ready[2] = 1'b0; ch_mem_wr[2] = 1'b0;
    tick();
    chk("t1_start_one_cycle", 32'(ch_start), 0);
    repeat (3000) tick();
    chk("t1_no_done_while_run", 32'(done_valid), 0);
    chk("t1_busy_run", 32'(ch_busy), 32'h4);
    ch_out_ready[2] = 1'b1;
    tick();
    chk("t1_done_valid", 32'(done_valid), 1);
    chk("t1_done_ch", 32'(done_ch), 2);
    chk("t1_done_err", 32'(done_err), 0);
    chk("t1_busy_free", 32'(ch_busy), 0);
    done_ready = 1'b1;
    tick();
    chk("t1_done_cleared", 32'(done_valid), 0);
    done_ready = 1'b0; ch_out_ready = '0;

    // four channels finishing in the same cycle drain in index order
    ch_start_ready = 4'hF; ch_mem_wr = 4'hF;
    for (int c = 0; c < 4; c++) begin
      job_valid = 1'b1; job_ch = 2'(c);
      tick();
    end
    job_valid = 1'b0;
    repeat (3) tick();
    chk("t2_all_busy", 32'(ch_busy), 32'hF);
    ch_start_ready = '0; ch_mem_wr = '0;
    tick();
    ch_out_ready = 4'hF;
    tick();
    chk("t2_first_valid", 32'(done_valid), 1);
    chk("t2_first_ch", 32'(done_ch), 0);
    chk("t2_all_free", 32'(ch_busy), 0);
    tick();
    chk("t2_hold_valid", 32'(done_valid), 1);
    chk("t2_hold_ch", 32'(done_ch), 0);
    done_ready = 1'b1;
    for (int c = 1; c < 4; c++) begin
      tick();
      chk("t2_seq_valid", 32'(done_valid), 1);
      chk("t2_seq_ch", 32'(done_ch), 32'(c));
    end
    tick();
    chk("t2_drained", 32'(done_valid), 0);
    done_ready = 1'b0; ch_out_ready = '0;

    // two jobs to ch1: second waits for first record; also stale/unqualified output_ready
    ch_start_ready[1] = 1'b1; ch_mem_wr[1] = 1'b1;
    job_valid = 1'b1; job_ch = 2'd1;
    tick();
    chk("t3_q1", 32'(q_count), 1);
    tick();
    job_valid = 1'b0;
    chk("t3_q_push_pop", 32'(q_count), 1);
    tick();
    chk("t3_start1", 32'(ch_start), 32'h2);
    ch_mem_wr[1] = 1'b0;
    tick();
    ch_out_ready[1] = 1'b1;
    tick();
    chk("t3_done1_ch", 32'(done_ch), 1);
    chk("t3_done1_valid", 32'(done_valid), 1);
    tick();
    chk("t3_blocked_by_pend", 32'(q_count), 1);
    chk("t3_no_second_start", 32'(ch_start), 0);
    done_ready = 1'b1; ch_mem_wr[1] = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("t3_q_still1", 32'(q_count), 1);
    tick();
    chk("t3_q0", 32'(q_count), 0);
    chk("t3_busy2", 32'(ch_busy), 32'h2);
    tick();
    chk("t3_start2", 32'(ch_start), 32'h2);
    repeat (3) tick();
    chk("t5_stale_high", 32'(done_valid), 0);
    ch_out_ready[1] = 1'b0; tick();
    ch_out_ready[1] = 1'b1; tick();
    chk("t5_rise_without_memwr_low", 32'(done_valid), 0);
    ch_mem_wr[1] = 1'b0; tick();
    chk("t5_memwr_low_no_done", 32'(done_valid), 0);
    ch_out_ready[1] = 1'b0; tick();
    ch_out_ready[1] = 1'b1; tick();
    chk("t5_qualified_done", 32'(done_valid), 1);
    chk("t5_qualified_ch", 32'(done_ch), 1);
    done_ready = 1'b1; tick();
    done_ready = 1'b0; ch_out_ready = '0; ch_start_ready = '0;

    // fill queue behind a running ch0, refuse the overflow push
    ch_start_ready[0] = 1'b1; ch_mem_wr[0] = 1'b1;
    job_valid = 1'b1; job_ch = 2'd0;
    repeat (10) tick();
    chk("t4_q_full", 32'(q_count), 8);
    chk("t4_job_ready_low", 32'(job_ready), 0);
    ch_mem_wr[0] = 1'b0;
    tick();
    chk("t4_refused", 32'(q_count), 8);
    ch_out_ready[0] = 1'b1;
    tick();
    chk("t4_done_ch0", 32'(done_valid), 1);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("t4_q_before_pop", 32'(q_count), 8);
    tick();
    job_valid = 1'b0;
    chk("t4_pop_push_refused", 32'(q_count), 7);
    chk("t4_job_ready_back", 32'(job_ready), 1);
    ch_mem_wr[0] = 1'b1; ch_out_ready[0] = 1'b0;
    tick();
    chk("t4_start_ch0", 32'(ch_start), 32'h1);

    // reset mid-RUN drops everything; later rise ignored
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_busy", 32'(ch_busy), 0);
    chk("t6_rst_done", 32'(done_valid), 0);
    chk("t6_rst_q", 32'(q_count), 0);
    chk("t6_rst_ready", 32'(job_ready), 1);
    ch_mem_wr[0] = 1'b0; tick();
    ch_out_ready[0] = 1'b1; tick(); tick();
    chk("t6_rise_ignored", 32'(done_valid), 0);
    chk("t6_still_free", 32'(ch_busy), 0);
    ch_out_ready = '0; ch_start_ready = '0;

`ifdef NWC_SCHED_WATCHDOG_EN
    // watchdog: ch3 never completes
    ch_start_ready[3] = 1'b1; ch_mem_wr[3] = 1'b1;
    job_valid = 1'b1; job_ch = 2'd3;
    tick();
    job_valid = 1'b0;
    tick(); tick();
    chk("wd_start", 32'(ch_start), 32'h8);
    ch_mem_wr[3] = 1'b0;
    repeat (99) tick();
    chk("wd_not_yet", 32'(done_valid), 0);
    tick();
    chk("wd_done_valid", 32'(done_valid), 1);
    chk("wd_done_ch", 32'(done_ch), 3);
    chk("wd_done_err", 32'(done_err), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
